// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: reads each instruction as four little-endian bytes over a
// shared byte-wide 1-cycle-latency port and presents (pc, inst) to IF/ID under valid/ready.
module if_fetch #(
  parameter int unsigned            ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              out_ready_i,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o
);

  localparam int unsigned CntW     = 3;
  localparam int unsigned InstW    = 32;
  localparam int unsigned BufW     = InstW - 8;
  localparam int unsigned NumBytes = 4;

  typedef enum logic {FETCH, VALID} state_e;

  state_e             state, state_n;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_n;
  logic [CntW-1:0]    issue_cnt, issue_cnt_n;
  logic               inflight, inflight_n;
  logic [1:0]         inflight_idx, inflight_idx_n;
  logic [BufW-1:0]    inst_buf, inst_buf_n;
  logic               req_n;
  logic [ADDR_W-1:0]  addr_n;
  logic               valid_n;
  logic [ADDR_W-1:0]  pc_n;
  logic [InstW-1:0]   inst_n;
  logic               accepted;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Next-state, byte assembly and lookahead request generation.
  always_comb begin
    accepted       = mem_req_o & mem_gnt_i;
    state_n        = state;
    fetch_pc_n     = fetch_pc;
    issue_cnt_n    = issue_cnt;
    inflight_n     = 1'b0;
    inflight_idx_n = issue_cnt[1:0];
    inst_buf_n     = inst_buf;
    valid_n        = inst_valid_o;
    pc_n           = pc_o;
    inst_n         = inst_o;

    if (redirect_i) begin
      state_n     = FETCH;
      fetch_pc_n  = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      issue_cnt_n = '0;
      valid_n     = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (accepted) begin
            issue_cnt_n = issue_cnt + CntW'(1);
            inflight_n  = 1'b1;
          end
          if (inflight) begin
            case (inflight_idx)
              2'd0: inst_buf_n[7:0]   = mem_rdata_i;
              2'd1: inst_buf_n[15:8]  = mem_rdata_i;
              2'd2: inst_buf_n[23:16] = mem_rdata_i;
              default: begin
                inst_n  = {mem_rdata_i, inst_buf};
                pc_n    = fetch_pc;
                valid_n = 1'b1;
                state_n = VALID;
              end
            endcase
          end
        end
        VALID: begin
          if (out_ready_i) begin
            valid_n     = 1'b0;
            fetch_pc_n  = fetch_pc + ADDR_W'(NumBytes);
            issue_cnt_n = '0;
            state_n     = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end

    req_n  = (state_n == FETCH) && (issue_cnt_n < CntW'(NumBytes));
    addr_n = fetch_pc_n + ADDR_W'(issue_cnt_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH;
      fetch_pc     <= RESET_PC;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      inst_buf     <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      inst_valid_o <= 1'b0;
      pc_o         <= '0;
      inst_o       <= '0;
    end else begin
      state        <= state_n;
      fetch_pc     <= fetch_pc_n;
      issue_cnt    <= issue_cnt_n;
      inflight     <= inflight_n;
      inflight_idx <= inflight_idx_n;
      inst_buf     <= inst_buf_n;
      mem_req_o    <= req_n;
      mem_addr_o   <= addr_n;
      inst_valid_o <= valid_n;
      pc_o         <= pc_n;
      inst_o       <= inst_n;
    end
  end

endmodule
